// File: rtl/xadac_rd_arbiter.sv
// xadac_rd_arbiter
//   Shares one single-beat AXI read port (AR + R) among NumReq requesters.
//   AR: round-robin grant into a single output register; the requester index
//       is prefixed onto the AXI ID ({idx, id}).
//   R : one-entry buffer; beats are routed back to the owner by the ID prefix.
//   Both directions are registered, so requester and memory are decoupled.
//
// Optional feature (macro XADAC_RD_ARB_LIMIT_EN):
//   per-requester outstanding counters; a requester with MaxOut reads in
//   flight is masked from arbitration until one of its beats is delivered.
//
// Ports
//   clk, rstn                      clock (rising edge), async reset (active low)
//   req_ar_id/addr/valid/ready     per-requester AR channel, requester i at slice i
//   req_r_id/data/valid/ready      per-requester R channel, requester i at slice i
//   mst_ar_id/addr/valid/ready     shared master AR channel, id = {idx, id}
//   mst_r_id/data/valid/ready      shared master R channel, id = {idx, id}

module xadac_rd_arbiter #(
  parameter int NumReq    = 2,
  parameter int IdWidth   = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 128,
  parameter int MaxOut    = 4,
  localparam int IdxWidth   = $clog2(NumReq),
  localparam int MstIdWidth = IdxWidth + IdWidth
) (
  input  logic                          clk,
  input  logic                          rstn,

  input  logic [NumReq*IdWidth-1:0]     req_ar_id,
  input  logic [NumReq*AddrWidth-1:0]   req_ar_addr,
  input  logic [NumReq-1:0]             req_ar_valid,
  output logic [NumReq-1:0]             req_ar_ready,

  output logic [NumReq*IdWidth-1:0]     req_r_id,
  output logic [NumReq*DataWidth-1:0]   req_r_data,
  output logic [NumReq-1:0]             req_r_valid,
  input  logic [NumReq-1:0]             req_r_ready,

  output logic [MstIdWidth-1:0]         mst_ar_id,
  output logic [AddrWidth-1:0]          mst_ar_addr,
  output logic                          mst_ar_valid,
  input  logic                          mst_ar_ready,

  input  logic [MstIdWidth-1:0]         mst_r_id,
  input  logic [DataWidth-1:0]          mst_r_data,
  input  logic                          mst_r_valid,
  output logic                          mst_r_ready
);

  // ---------------------------------------------------------------------------
  // AR arbitration
  // ---------------------------------------------------------------------------
  logic [IdxWidth-1:0]  rr_ptr;
  logic [NumReq-1:0]    eligible;
  logic [NumReq-1:0]    grant_oh;
  logic [IdxWidth-1:0]  grant_idx;
  logic                 grant_any;
  logic                 ar_free;
  logic [IdxWidth:0]    pos;
  logic [IdWidth-1:0]   sel_id;
  logic [AddrWidth-1:0] sel_addr;
  logic [IdxWidth-1:0]  rr_nxt;

  assign ar_free = !mst_ar_valid || mst_ar_ready;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int k = 0; k < NumReq; k++) begin
      // walk rr_ptr, rr_ptr+1, ... wrapping at NumReq (which need not be 2^n)
      pos = {1'b0, rr_ptr} + (IdxWidth+1)'(k);
      if (pos >= (IdxWidth+1)'(NumReq))
        pos = pos - (IdxWidth+1)'(NumReq);
      if (!grant_any && eligible[pos[IdxWidth-1:0]]) begin
        grant_any                     = 1'b1;
        grant_idx                     = pos[IdxWidth-1:0];
        grant_oh[pos[IdxWidth-1:0]]   = 1'b1;
      end
    end
    // no grant while the register is busy or the block is held in reset
    if (!ar_free || !rstn) begin
      grant_any = 1'b0;
      grant_oh  = '0;
    end
  end

  assign req_ar_ready = grant_oh;

  always_comb begin
    sel_id   = '0;
    sel_addr = '0;
    for (int i = 0; i < NumReq; i++) begin
      sel_id   = sel_id   | (req_ar_id[i*IdWidth +: IdWidth]       & {IdWidth{grant_oh[i]}});
      sel_addr = sel_addr | (req_ar_addr[i*AddrWidth +: AddrWidth] & {AddrWidth{grant_oh[i]}});
    end
  end

  assign rr_nxt = (grant_idx == IdxWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mst_ar_id    <= '0;
      mst_ar_addr  <= '0;
      mst_ar_valid <= 1'b0;
      rr_ptr       <= '0;
    end else if (grant_any) begin
      mst_ar_id    <= {grant_idx, sel_id};
      mst_ar_addr  <= sel_addr;
      mst_ar_valid <= 1'b1;
      rr_ptr       <= rr_nxt;
    end else if (mst_ar_valid && mst_ar_ready) begin
      mst_ar_id    <= '0;
      mst_ar_addr  <= '0;
      mst_ar_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // R routing buffer
  // ---------------------------------------------------------------------------
  logic                 buf_valid;
  logic [IdxWidth-1:0]  buf_idx;
  logic [IdWidth-1:0]   buf_id;
  logic [DataWidth-1:0] buf_data;
  logic                 idx_ok;
  logic                 sel_ready;
  logic                 drain;

  always_comb begin
    idx_ok    = 1'b0;
    sel_ready = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (buf_idx == IdxWidth'(i)) begin
        idx_ok    = 1'b1;
        sel_ready = req_r_ready[i];
      end
    end
  end

  assign mst_r_ready = !buf_valid || (idx_ok && sel_ready);
  // a beat with an unknown owner leaves the buffer unconditionally
  assign drain       = buf_valid && (!idx_ok || sel_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_id    <= '0;
      buf_data  <= '0;
    end else if (mst_r_valid && mst_r_ready) begin
      buf_valid <= 1'b1;
      buf_idx   <= mst_r_id[MstIdWidth-1 -: IdxWidth];
      buf_id    <= mst_r_id[IdWidth-1:0];
      buf_data  <= mst_r_data;
    end else if (drain) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_id    <= '0;
      buf_data  <= '0;
    end
  end

  always_comb begin
    req_r_valid = '0;
    req_r_id    = '0;
    req_r_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (buf_valid && buf_idx == IdxWidth'(i)) begin
        req_r_valid[i]                       = 1'b1;
        req_r_id[i*IdWidth +: IdWidth]       = buf_id;
        req_r_data[i*DataWidth +: DataWidth] = buf_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding limit
  // ---------------------------------------------------------------------------
`ifdef XADAC_RD_ARB_LIMIT_EN
  localparam int CntWidth = $clog2(MaxOut + 1);

  logic [CntWidth-1:0] cnt [NumReq];
  logic [NumReq-1:0]   cnt_inc;
  logic [NumReq-1:0]   cnt_dec;

  assign cnt_inc = req_ar_ready;
  assign cnt_dec = req_r_valid & req_r_ready;

  always_comb begin
    for (int i = 0; i < NumReq; i++)
      eligible[i] = req_ar_valid[i] && (cnt[i] != CntWidth'(MaxOut));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NumReq; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])
          cnt[i] <= cnt[i] + 1'b1;
        else if (!cnt_inc[i] && cnt_dec[i])
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < NumReq; i++)
        cnt_no_underflow : assert (!(cnt_dec[i] && !cnt_inc[i] && cnt[i] == '0));
    end
  end
`else
  assign eligible = req_ar_valid;
`endif

endmodule

// File: tb/tb_xadac_rd_arbiter.sv
// tb_xadac_rd_arbiter
//   Directed-vector bench for xadac_rd_arbiter with NumReq=2, IdWidth=4,
//   AddrWidth=32, DataWidth=128, MaxOut=2. Expectations that depend on the
//   outstanding limit follow XADAC_RD_ARB_LIMIT_EN.

module tb_xadac_rd_arbiter;

  localparam int NumReq = 2;
  localparam int IdW    = 4;
  localparam int AW     = 32;
  localparam int DW     = 128;
  localparam int MIdW   = 5;

`ifdef XADAC_RD_ARB_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  logic                  clk;
  logic                  rstn;
  logic [NumReq*IdW-1:0] req_ar_id;
  logic [NumReq*AW-1:0]  req_ar_addr;
  logic [NumReq-1:0]     req_ar_valid;
  logic [NumReq-1:0]     req_ar_ready;
  logic [NumReq*IdW-1:0] req_r_id;
  logic [NumReq*DW-1:0]  req_r_data;
  logic [NumReq-1:0]     req_r_valid;
  logic [NumReq-1:0]     req_r_ready;
  logic [MIdW-1:0]       mst_ar_id;
  logic [AW-1:0]         mst_ar_addr;
  logic                  mst_ar_valid;
  logic                  mst_ar_ready;
  logic [MIdW-1:0]       mst_r_id;
  logic [DW-1:0]         mst_r_data;
  logic                  mst_r_valid;
  logic                  mst_r_ready;

  int n_vec;
  int n_err;

  xadac_rd_arbiter #(
    .NumReq(NumReq), .IdWidth(IdW), .AddrWidth(AW), .DataWidth(DW), .MaxOut(2)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_ar_id(req_ar_id), .req_ar_addr(req_ar_addr),
    .req_ar_valid(req_ar_valid), .req_ar_ready(req_ar_ready),
    .req_r_id(req_r_id), .req_r_data(req_r_data),
    .req_r_valid(req_r_valid), .req_r_ready(req_r_ready),
    .mst_ar_id(mst_ar_id), .mst_ar_addr(mst_ar_addr),
    .mst_ar_valid(mst_ar_valid), .mst_ar_ready(mst_ar_ready),
    .mst_r_id(mst_r_id), .mst_r_data(mst_r_data),
    .mst_r_valid(mst_r_valid), .mst_r_ready(mst_r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req_ar_id    = '0;
    req_ar_addr  = '0;
    req_ar_valid = '0;
    req_r_ready  = '0;
    mst_ar_ready = 1'b0;
    mst_r_id     = '0;
    mst_r_data   = '0;
    mst_r_valid  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b1;
    clear_inputs();

    // ---- reset with random inputs ----
    #2 rstn = 1'b0;
    req_ar_id    = NumReq*IdW'($urandom);
    req_ar_addr  = {$urandom, $urandom};
    req_ar_valid = 2'b11;
    req_r_ready  = NumReq'($urandom);
    mst_ar_ready = 1'($urandom);
    mst_r_id     = MIdW'($urandom);
    mst_r_data   = {$urandom, $urandom, $urandom, $urandom};
    mst_r_valid  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ar_valid", mst_ar_valid, 0);
    check("rst_ar_id",    mst_ar_id,    0);
    check("rst_ar_addr",  mst_ar_addr,  0);
    check("rst_ar_ready", req_ar_ready, 0);
    check("rst_r_valid",  req_r_valid,  0);
    check("rst_r_id",     req_r_id,     0);
    check("rst_r_data0",  req_r_data[127:0],   0);
    check("rst_r_data1",  req_r_data[255:128], 0);
    check("rst_r_ready",  mst_r_ready,  1);
    @(negedge clk);
    clear_inputs();
    rstn = 1'b1;

    // ---- round robin, both requesters always valid ----
    @(negedge clk);
    req_ar_id    = {4'd5, 4'd3};
    req_ar_addr  = {32'h0000_00B0, 32'h0000_00A0};
    req_ar_valid = 2'b11;
    mst_ar_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 check("rr_ready", req_ar_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      check("rr_id",    mst_ar_id,    (c % 2 == 0) ? 5'h03 : 5'h15);
      check("rr_addr",  mst_ar_addr,  (c % 2 == 0) ? 32'hA0 : 32'hB0);
      check("rr_valid", mst_ar_valid, 1);
    end
    req_ar_valid = 2'b00;
    @(negedge clk);
    check("rr_idle", mst_ar_valid, 0);

    // ---- AR backpressure ----
    do_reset();
    mst_ar_ready     = 1'b0;
    req_ar_id[3:0]   = 4'd2;
    req_ar_addr[31:0]= 32'h0000_1000;
    req_ar_valid     = 2'b01;
    #1 check("bp_first_ready", req_ar_ready, 2'b01);
    @(negedge clk);
    req_ar_valid       = 2'b10;
    req_ar_id[7:4]     = 4'd6;
    req_ar_addr[63:32] = 32'h0000_2000;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("bp_addr",  mst_ar_addr,  32'h1000);
      check("bp_id",    mst_ar_id,    5'h02);
      check("bp_valid", mst_ar_valid, 1);
      check("bp_ready", req_ar_ready, 2'b00);
      @(negedge clk);
    end
    mst_ar_ready = 1'b1;
    #1 check("bp_release_ready", req_ar_ready, 2'b10);
    @(negedge clk);
    req_ar_valid = 2'b00;
    check("bp_next_addr", mst_ar_addr, 32'h2000);
    check("bp_next_id",   mst_ar_id,   5'h16);
    @(negedge clk);
    check("bp_done_valid", mst_ar_valid, 0);

    // ---- R routing and back-to-back drain/accept (one read each outstanding) ----
    mst_r_valid = 1'b1;
    mst_r_id    = 5'h17;
    mst_r_data  = {16{8'hA5}};
    req_r_ready = 2'b00;
    #1 check("r_empty_ready", mst_r_ready, 1);
    @(negedge clk);
    mst_r_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("r_hold_valid", req_r_valid, 2'b10);
      check("r_hold_id",    req_r_id,    8'h70);
      check("r_hold_data1", req_r_data[255:128], {16{8'hA5}});
      check("r_hold_data0", req_r_data[127:0],   0);
      check("r_hold_mready", mst_r_ready, 0);
      @(negedge clk);
    end
    req_r_ready = 2'b11;
    mst_r_valid = 1'b1;
    mst_r_id    = 5'h09;
    mst_r_data  = {16{8'h5A}};
    #1;
    check("r_drain_mready", mst_r_ready, 1);
    check("r_drain_valid",  req_r_valid, 2'b10);
    @(negedge clk);
    mst_r_valid = 1'b0;
    #1;
    check("r_next_valid", req_r_valid, 2'b01);
    check("r_next_id",    req_r_id,    8'h09);
    check("r_next_data0", req_r_data[127:0],   {16{8'h5A}});
    check("r_next_data1", req_r_data[255:128], 0);
    @(negedge clk);
    check("r_empty_again", req_r_valid, 2'b00);
    req_r_ready = 2'b00;

    // ---- outstanding limit on requester 0 ----
    do_reset();
    mst_ar_ready   = 1'b1;
    req_ar_id[3:0] = 4'd1;
    req_ar_valid   = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1 check("lim_ready", req_ar_ready, (c < 2) ? 2'b01 : (LimitEn ? 2'b00 : 2'b01));
      @(negedge clk);
    end
    mst_r_valid = 1'b1;
    mst_r_id    = 5'h01;
    mst_r_data  = 128'h1234;
    req_r_ready = 2'b01;
    #1 check("lim_masked", req_ar_ready, LimitEn ? 2'b00 : 2'b01);
    @(negedge clk);
    mst_r_valid = 1'b0;
    #1;
    check("lim_r_valid",   req_r_valid, 2'b01);
    check("lim_hs_masked", req_ar_ready, LimitEn ? 2'b00 : 2'b01);
    @(negedge clk);
    #1 check("lim_regrant", req_ar_ready, 2'b01);
    @(negedge clk);
    req_ar_valid = 2'b00;
    req_r_ready  = 2'b00;

    // ---- simultaneous grant and R handshake on requester 1 ----
    do_reset();
    mst_ar_ready   = 1'b1;
    req_ar_id[7:4] = 4'd8;
    req_ar_valid   = 2'b10;
    #1 check("sim_first_grant", req_ar_ready, 2'b10);
    @(negedge clk);
    req_ar_valid = 2'b00;
    mst_r_valid  = 1'b1;
    mst_r_id     = 5'h14;
    mst_r_data   = 128'hCAFE_F00D;
    @(negedge clk);
    mst_r_valid  = 1'b0;
    req_r_ready  = 2'b10;
    req_ar_valid = 2'b10;
    #1;
    check("sim_r_valid", req_r_valid, 2'b10);
    check("sim_r_id",    req_r_id,    8'h40);
    check("sim_r_data",  req_r_data[255:128], 128'hCAFE_F00D);
    check("sim_grant",   req_ar_ready, 2'b10);
    @(negedge clk);
    #1;
    check("sim_no_dup",     req_r_valid,  2'b00);
    check("sim_grant_two",  req_ar_ready, 2'b10);
    @(negedge clk);
    #1 check("sim_grant_three", req_ar_ready, LimitEn ? 2'b00 : 2'b10);
    @(negedge clk);
    req_ar_valid = 2'b00;
    req_r_ready  = 2'b00;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
